// File: rtl/itype_pkg.sv
// ============================================================================
// Module      : itype_pkg
// Description : Shared definitions for the RV32 I-type encoder: opcode and
//               funct3 constants, field bit positions, the field-set struct
//               and small helpers for range checking, clamping and packing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package itype_pkg;

  // Opcodes accepted by the encoder
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // funct3 values of the I-type family
  localparam logic [2:0] F3_ADDI  = 3'b000;
  localparam logic [2:0] F3_SLTI  = 3'b010;
  localparam logic [2:0] F3_SLTIU = 3'b011;
  localparam logic [2:0] F3_XORI  = 3'b100;
  localparam logic [2:0] F3_ORI   = 3'b110;
  localparam logic [2:0] F3_ANDI  = 3'b111;
  localparam logic [2:0] F3_LB    = 3'b000;
  localparam logic [2:0] F3_LH    = 3'b001;
  localparam logic [2:0] F3_LW    = 3'b010;
  localparam logic [2:0] F3_LBU   = 3'b100;
  localparam logic [2:0] F3_LHU   = 3'b101;
  localparam logic [2:0] F3_JALR  = 3'b000;

  // Field bit positions inside the 32-bit instruction word
  localparam int IMM_MSB = 31;
  localparam int IMM_LSB = 20;
  localparam int RS1_LSB = 15;
  localparam int F3_LSB  = 12;
  localparam int RD_LSB  = 7;

  // Already-truncated field set, ready for packing
  typedef struct packed {
    logic [11:0] imm;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } itype_fields_t;

  // True when the opcode belongs to the supported I-type family
  function automatic logic opcode_is_legal(input logic [6:0] opc);
    return (opc == OPC_OP_IMM) || (opc == OPC_LOAD) || (opc == OPC_JALR);
  endfunction

  // A 32-bit two's complement value fits 12 bits signed when the upper
  // 21 bits are a pure sign extension of bit 11.
  function automatic logic imm_fits12(input logic [31:0] imm);
    return (imm[31:11] == 21'h000000) || (imm[31:11] == 21'h1FFFFF);
  endfunction

  // Clamp to [-2048, 2047]; in-range values pass through unchanged
  function automatic logic [11:0] imm_sat12(input logic [31:0] imm);
    logic [11:0] r;
    if (imm_fits12(imm)) begin
      r = imm[11:0];
    end else if (imm[31]) begin
      r = 12'h800;
    end else begin
      r = 12'h7FF;
    end
    return r;
  endfunction

  // Pure bit placement of the fields into an I-type word
  function automatic logic [31:0] pack_itype(input itype_fields_t f);
    logic [31:0] w;
    w                     = '0;
    w[IMM_MSB:IMM_LSB]    = f.imm;
    w[RS1_LSB +: 5]       = f.rs1;
    w[F3_LSB +: 3]        = f.funct3;
    w[RD_LSB +: 5]        = f.rd;
    w[RD_LSB-1:0]         = f.opcode;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/itype_enc_fifo.sv
// ============================================================================
// Module      : itype_enc_fifo
// Description : Generic DEPTH x WIDTH synchronous FIFO with push/pop and an
//               occupancy count. DEPTH must be a power of two (>= 2) so the
//               pointers wrap naturally. The head output reads as zero while
//               the FIFO is empty.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module itype_enc_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1),
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign count     = r_count;
  assign dout      = empty ? '0 : r_mem[r_rptr];

  // Storage array; contents need no reset because the head is masked when empty
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= din;
    end
  end

  // Pointer and occupancy tracking; reset discards everything at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/itype_encoder.sv
// ============================================================================
// Module      : itype_encoder
// Description : Packs RV32 I-type fields (ADDI / load / JALR family) into
//               32-bit instruction words, validates opcode and immediate
//               range, and buffers legal words in a small FIFO with
//               valid/ready on both sides. Rejected field sets are consumed
//               and reported with one-cycle error pulses.
//               Optional build macro ITYPE_ENC_IMM_SAT_EN: out-of-range
//               immediates are clamped to 2047 / -2048 and still enqueued
//               (err_range still pulses).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module itype_encoder
  import itype_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [2:0]       in_funct3,
  input  logic [4:0]       in_rs1,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             err_range,
  output logic             err_opcode,
  output logic [CNT_W-1:0] count
);

  logic             w_accept;
  logic             w_opc_ok;
  logic             w_imm_ok;
  logic             w_enq_ok;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  itype_fields_t    w_fields;
  logic [31:0]      w_word;
  logic             r_err_range;
  logic             r_err_opcode;

  // in_ready depends only on registered occupancy, never on out_ready
  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign w_accept  = in_valid && in_ready;
  assign w_opc_ok  = opcode_is_legal(in_opcode);
  assign w_imm_ok  = imm_fits12(in_imm);
  assign w_push    = w_accept && w_enq_ok;
  assign w_pop     = out_valid && out_ready;
  assign w_word    = pack_itype(w_fields);

  // Field selection and enqueue qualification; the immediate policy is build-selectable
  always_comb begin
    w_fields        = '0;
    w_fields.opcode = in_opcode;
    w_fields.rd     = in_rd;
    w_fields.funct3 = in_funct3;
    w_fields.rs1    = in_rs1;
`ifdef ITYPE_ENC_IMM_SAT_EN
    w_fields.imm    = imm_sat12(in_imm);
    w_enq_ok        = w_opc_ok;
`else
    w_fields.imm    = in_imm[11:0];
    w_enq_ok        = w_opc_ok && w_imm_ok;
`endif
  end

  // Error pulses appear in the cycle after the offending field set is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_range  <= 1'b0;
      r_err_opcode <= 1'b0;
    end else begin
      r_err_range  <= w_accept && !w_imm_ok;
      r_err_opcode <= w_accept && !w_opc_ok;
    end
  end

  assign err_range  = r_err_range;
  assign err_opcode = r_err_opcode;

  itype_enc_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   (w_word),
    .pop   (w_pop),
    .dout  (out_instr),
    .count (count),
    .full  (w_full),
    .empty (w_empty)
  );

endmodule

`default_nettype wire
